// File: rtl/seq_divider4_if.sv
// Handshake/operand bundle for the sequential restoring divider.
// The controller drives start and the operands; the divider returns status and results.
interface seq_divider4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider4.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// Flow is IDLE -> CALC (WIDTH edges) -> DONE; a zero divisor skips CALC and flags div_by_zero.

// One restoring step: shift the next dividend bit into the partial remainder,
// then subtract the divisor if the result does not go negative.
module seq_divider4_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  // The full partial remainder is kept: with a large divisor its MSB can be set,
  // so the trial value needs WIDTH+1 bits.
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {i_prem, i_bit};
  assign w_diff  = w_trial - {1'b0, i_dvs};
  assign o_qbit  = (w_trial >= {1'b0, i_dvs});
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
endmodule

module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider4_if.slave s
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_qacc;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic             r_zpend;

  logic [WIDTH-1:0] w_nrem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_qnext;

  seq_divider4_step #(.WIDTH(WIDTH)) u_step (
    .i_prem (r_prem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_nrem),
    .o_qbit (w_qbit)
  );

  assign w_qnext = {r_qacc[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_qacc  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_zpend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A zero divisor spends one idle cycle before DONE so its done pulse
          // lands one cycle after the capture edge; start is ignored meanwhile.
          if (r_zpend) begin
            r_zpend <= 1'b0;
            r_quot  <= '1;
            r_rem   <= r_dvd;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (s.start) begin
            r_dvd <= s.dividend;
            r_dvs <= s.divisor;
            if (s.divisor == '0) begin
              r_zpend <= 1'b1;
            end else begin
              r_prem  <= '0;
              r_qacc  <= '0;
              r_cnt   <= CW'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_prem <= w_nrem;
          r_qacc <= w_qnext;
          r_dvd  <= r_dvd << 1;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quot  <= w_qnext;
            r_rem   <= w_nrem;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.busy        = r_busy;
  assign s.done        = r_done;
  assign s.quotient    = r_quot;
  assign s.remainder   = r_rem;
  assign s.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider4.sv
// Directed bench for seq_divider4: vector table, handshake corner cases and a full 4-bit sweep.
module tb_seq_divider4;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_divider4_if #(.WIDTH(4)) bus ();

  seq_divider4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         bcnt;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Issues one divide and returns at the done cycle (or after the cycle budget).
  // lat counts edges after the capture edge; bcnt counts busy cycles seen.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int bcnt, output int ovlp);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 4'($urandom);
    bus.divisor  = 4'($urandom);
    lat = 0; bcnt = 0; ovlp = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) ovlp = 1;
  endtask

  initial begin
    vec_t tbl[8];
    int lat, bcnt, ovlp, dcnt, gq, gr;
    n_vec = 0;
    n_err = 0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4, 4};
    tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4, 4};
    tbl[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 4, 4};
    tbl[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4, 4};
    tbl[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4, 4};
    tbl[5] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 4, 4};
    tbl[6] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1, 0};
    tbl[7] = '{4'd6,  4'd4,  4'd1,  4'd2, 1'b0, 4, 4};

    // Reset and idle behaviour
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);

    // Table of directed divides
    for (int i = 0; i < 8; i++) begin
      do_div(tbl[i].a, tbl[i].b, lat, bcnt, ovlp);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_busycyc", i), bcnt, tbl[i].bcnt);
      chk($sformatf("v%0d_overlap", i), ovlp, 0);
      chk($sformatf("v%0d_q", i), bus.quotient, tbl[i].q);
      chk($sformatf("v%0d_r", i), bus.remainder, tbl[i].r);
      chk($sformatf("v%0d_dbz", i), bus.div_by_zero, tbl[i].dbz);
      @(negedge clk);
      chk($sformatf("v%0d_done_fall", i), bus.done, 0);
    end

    // start and operand changes during CALC are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 4'd1; bus.divisor = 4'd1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd10; bus.divisor = 4'd2;
    dcnt = 0; gq = 0; gr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = 4'($urandom);
      bus.divisor  = 4'($urandom);
      if (bus.done) begin
        dcnt++;
        gq = bus.quotient;
        gr = bus.remainder;
      end
    end
    chk("ign_done_pulses", dcnt, 1);
    chk("ign_q", gq, 4);
    chk("ign_r", gr, 2);
    chk("hold_q", bus.quotient, 4);
    chk("hold_r", bus.remainder, 2);

    // Outputs stay put during the next CALC
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("calc_busy", bus.busy, 1);
    chk("calc_hold_q", bus.quotient, 4);
    chk("calc_hold_r", bus.remainder, 2);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("next_done_seen", bus.done, 1);
    chk("next_q", bus.quotient, 5);
    chk("next_r", bus.remainder, 0);

    // Reset in the middle of a divide aborts it
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_q", bus.quotient, 0);
    chk("abort_r", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done || bus.busy) dcnt++;
      @(negedge clk);
    end
    chk("abort_quiet", dcnt, 0);
    do_div(4'd7, 4'd2, lat, bcnt, ovlp);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_q", bus.quotient, 3);
    chk("post_abort_r", bus.remainder, 1);

    // Exhaustive sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq, er, edz;
        do_div(4'(a), 4'(b), lat, bcnt, ovlp);
        if (b == 0) begin
          eq = 15; er = a; edz = 1;
        end else begin
          eq = a / b; er = a % b; edz = 0;
        end
        chk($sformatf("sweep_%0d_%0d", a, b),
            {bus.quotient, bus.remainder, bus.div_by_zero, lat[5:0]},
            {4'(eq), 4'(er), 1'(edz), (b == 0) ? 6'd1 : 6'd4});
        if (b != 0)
          chk($sformatf("inv_%0d_%0d", a, b),
              int'(bus.quotient) * b + int'(bus.remainder) == a && int'(bus.remainder) < b, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
